// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory/refill port between the instruction cache and the data
//   cache. Request pulses are captured into one pending slot per requester and
//   issued to memory one at a time. Each memory response goes back to its owner
//   as a one-cycle ready pulse with data.
//
//   Optional feature macro: MEM_ARB_RR_EN
//     defined   : round-robin between the two caches when both are pending
//     undefined : fixed priority, the Dcache always wins
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   ic_valid_req_i, ic_addr_i        Icache request pulse and block address
//   ic_ready_o, ic_data_o            Icache response pulse and refill line
//   dc_valid_req_i, dc_we_i,
//   dc_addr_i, dc_wdata_i            Dcache request pulse, write flag, address, line
//   dc_ready_o, dc_rdata_o           Dcache response pulse and read line
//   mem_valid_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o          memory request pulse and held request fields
//   mem_ready_i, mem_rdata_i         memory response pulse and read line
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_valid_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ready_o,
  output logic [DATA_W-1:0] ic_data_o,
  input  logic              dc_valid_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_ready_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              mem_valid_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_IC, WAIT_DC} state_t;

  state_t            state;
  logic              drop;          // in-flight Icache response is stale
  logic              ic_pend;
  logic [ADDR_W-1:0] ic_slot_addr;
  logic              dc_pend;
  logic              dc_slot_we;
  logic [ADDR_W-1:0] dc_slot_addr;
  logic [DATA_W-1:0] dc_slot_wdata;
`ifdef MEM_ARB_RR_EN
  logic              last_dc;       // 1: last grant went to the Dcache
`endif

  logic              dc_take;
  logic              ic_eff;
  logic              dc_eff;
  logic              grant_ic;
  logic              grant_dc;
  logic [ADDR_W-1:0] ic_eff_addr;
  logic              dc_eff_we;
  logic [ADDR_W-1:0] dc_eff_addr;
  logic [DATA_W-1:0] dc_eff_wdata;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    dc_take      = 1'b0;
    ic_eff       = 1'b0;
    dc_eff       = 1'b0;
    grant_ic     = 1'b0;
    grant_dc     = 1'b0;
    ic_eff_addr  = ic_slot_addr;
    dc_eff_we    = dc_slot_we;
    dc_eff_addr  = dc_slot_addr;
    dc_eff_wdata = dc_slot_wdata;

    // A Dcache pulse is a protocol violation while one of its requests is
    // pending or in flight, except in the cycle its response arrives.
    dc_take = dc_valid_req_i && !dc_pend && !((state == WAIT_DC) && !mem_ready_i);

    // An incoming pulse is arbitrable in the cycle it arrives.
    ic_eff = ic_pend || ic_valid_req_i;
    dc_eff = dc_pend || dc_take;
    if (ic_valid_req_i) ic_eff_addr = ic_addr_i;
    if (dc_take) begin
      dc_eff_we    = dc_we_i;
      dc_eff_addr  = dc_addr_i;
      dc_eff_wdata = dc_wdata_i;
    end

    if (state == IDLE) begin
`ifdef MEM_ARB_RR_EN
      grant_dc = dc_eff && (!ic_eff || !last_dc);
`else
      grant_dc = dc_eff;
`endif
      grant_ic = ic_eff && !grant_dc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide slot and output registers are reset too, since every
      // output must read 0 straight out of reset.
      state           <= IDLE;
      drop            <= 1'b0;
      ic_pend         <= 1'b0;
      ic_slot_addr    <= '0;
      dc_pend         <= 1'b0;
      dc_slot_we      <= 1'b0;
      dc_slot_addr    <= '0;
      dc_slot_wdata   <= '0;
      ic_ready_o      <= 1'b0;
      ic_data_o       <= '0;
      dc_ready_o      <= 1'b0;
      dc_rdata_o      <= '0;
      mem_valid_req_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
`ifdef MEM_ARB_RR_EN
      last_dc         <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block ordered as if all happened together at the clock edge.
      ic_ready_o      <= 1'b0;
      dc_ready_o      <= 1'b0;
      mem_valid_req_o <= 1'b0;

      // Icache slot: a new pulse overwrites any pending address (latest wins).
      if (grant_ic) begin
        ic_pend <= 1'b0;
      end else if (ic_valid_req_i) begin
        ic_pend      <= 1'b1;
        ic_slot_addr <= ic_addr_i;
      end

      if (grant_dc) begin
        dc_pend <= 1'b0;
      end else if (dc_take) begin
        dc_pend       <= 1'b1;
        dc_slot_we    <= dc_we_i;
        dc_slot_addr  <= dc_addr_i;
        dc_slot_wdata <= dc_wdata_i;
      end

      unique case (state)
        IDLE: begin
          if (grant_dc) begin
            mem_valid_req_o <= 1'b1;
            mem_we_o        <= dc_eff_we;
            mem_addr_o      <= dc_eff_addr;
            mem_wdata_o     <= dc_eff_wdata;
            state           <= WAIT_DC;
`ifdef MEM_ARB_RR_EN
            last_dc         <= 1'b1;
`endif
          end else if (grant_ic) begin
            mem_valid_req_o <= 1'b1;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= ic_eff_addr;
            mem_wdata_o     <= '0;
            state           <= WAIT_IC;
`ifdef MEM_ARB_RR_EN
            last_dc         <= 1'b0;
`endif
          end
        end
        WAIT_IC: begin
          if (mem_ready_i) begin
            if (!drop) begin
              ic_ready_o <= 1'b1;
              ic_data_o  <= mem_rdata_i;
            end
            drop  <= 1'b0;
            state <= IDLE;
          end else if (ic_valid_req_i) begin
            // Redirect: the in-flight line is no longer wanted.
            drop <= 1'b1;
          end
        end
        WAIT_DC: begin
          if (mem_ready_i) begin
            dc_ready_o <= 1'b1;
            if (!mem_we_o) dc_rdata_o <= mem_rdata_i;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed, self-checking bench for mem_arbiter. Inputs change 1 ns after a
//   rising edge; registered outputs are sampled at the same point, i.e. they
//   show the cycle that follows that edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

`ifdef MEM_ARB_RR_EN
  localparam logic FIRST_IS_DC = 1'b0;  // last grant before the collision was DC
`else
  localparam logic FIRST_IS_DC = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ic_valid_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_ready_o;
  logic [DATA_W-1:0] ic_data_o;
  logic              dc_valid_req_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [DATA_W-1:0] dc_wdata_i;
  logic              dc_ready_o;
  logic [DATA_W-1:0] dc_rdata_o;
  logic              mem_valid_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ic_valid_req_i  (ic_valid_req_i),
    .ic_addr_i       (ic_addr_i),
    .ic_ready_o      (ic_ready_o),
    .ic_data_o       (ic_data_o),
    .dc_valid_req_i  (dc_valid_req_i),
    .dc_we_i         (dc_we_i),
    .dc_addr_i       (dc_addr_i),
    .dc_wdata_i      (dc_wdata_i),
    .dc_ready_o      (dc_ready_o),
    .dc_rdata_o      (dc_rdata_o),
    .mem_valid_req_o (mem_valid_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_ready_i     (mem_ready_i),
    .mem_rdata_i     (mem_rdata_i)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_valid"}, DATA_W'(mem_valid_req_o), '0);
    check({tag, "_mem_we"},    DATA_W'(mem_we_o),        '0);
    check({tag, "_mem_addr"},  DATA_W'(mem_addr_o),      '0);
    check({tag, "_mem_wdata"}, mem_wdata_o,              '0);
    check({tag, "_ic_ready"},  DATA_W'(ic_ready_o),      '0);
    check({tag, "_ic_data"},   ic_data_o,                '0);
    check({tag, "_dc_ready"},  DATA_W'(dc_ready_o),      '0);
    check({tag, "_dc_rdata"},  dc_rdata_o,               '0);
  endtask

  // One-cycle memory response, then back to the cycle after it.
  task automatic mem_respond(input logic [DATA_W-1:0] data);
    mem_ready_i = 1'b1;
    mem_rdata_i = data;
    tick();
    mem_ready_i = 1'b0;
  endtask

  task automatic ic_pulse(input logic [ADDR_W-1:0] addr);
    ic_valid_req_i = 1'b1;
    ic_addr_i      = addr;
    tick();
    ic_valid_req_i = 1'b0;
  endtask

  task automatic dc_pulse(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata);
    dc_valid_req_i = 1'b1;
    dc_we_i        = we;
    dc_addr_i      = addr;
    dc_wdata_i     = wdata;
    tick();
    dc_valid_req_i = 1'b0;
  endtask

  logic [DATA_W-1:0] d_a5, d_1234, d_dead, d_5a, d_11, d_33, d_77, d_88, d_c3;

  initial begin
    d_a5   = {16{8'hA5}};
    d_1234 = {8{16'h1234}};
    d_dead = {4{32'hDEAD_BEEF}};
    d_5a   = {16{8'h5A}};
    d_11   = {16{8'h11}};
    d_33   = {16{8'h33}};
    d_77   = {16{8'h77}};
    d_88   = {16{8'h88}};
    d_c3   = {16{8'hC3}};

    rst_n = 1'b0;
    ic_valid_req_i = 1'b0; ic_addr_i = '0;
    dc_valid_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("idle_no_req", DATA_W'(mem_valid_req_o), '0);

    // ---- single Icache read ----
    ic_pulse(32'h0000_0100);
    check("icrd_valid", DATA_W'(mem_valid_req_o), 1);
    check("icrd_addr",  DATA_W'(mem_addr_o), 32'h100);
    check("icrd_we",    DATA_W'(mem_we_o), 0);
    tick();
    check("icrd_one_pulse", DATA_W'(mem_valid_req_o), 0);
    mem_respond(d_a5);
    check("icrd_ready",    DATA_W'(ic_ready_o), 1);
    check("icrd_data",     ic_data_o, d_a5);
    check("icrd_dc_ready", DATA_W'(dc_ready_o), 0);
    tick();
    check("icrd_ready_end", DATA_W'(ic_ready_o), 0);
    check("icrd_data_hold", ic_data_o, d_a5);

    // ---- Dcache write ----
    dc_pulse(1'b1, 32'h2000, d_1234);
    check("dcwr_valid", DATA_W'(mem_valid_req_o), 1);
    check("dcwr_we",    DATA_W'(mem_we_o), 1);
    check("dcwr_addr",  DATA_W'(mem_addr_o), 32'h2000);
    check("dcwr_wdata", mem_wdata_o, d_1234);
    tick();
    mem_respond(d_dead);
    check("dcwr_ack",     DATA_W'(dc_ready_o), 1);
    check("dcwr_rdata",   dc_rdata_o, '0);
    check("dcwr_ic_rdy",  DATA_W'(ic_ready_o), 0);
    tick();
    check("dcwr_ack_end", DATA_W'(dc_ready_o), 0);

    // ---- Dcache read ----
    dc_pulse(1'b0, 32'h3000, '0);
    check("dcrd_addr", DATA_W'(mem_addr_o), 32'h3000);
    check("dcrd_we",   DATA_W'(mem_we_o), 0);
    mem_respond(d_5a);
    check("dcrd_ready", DATA_W'(dc_ready_o), 1);
    check("dcrd_data",  dc_rdata_o, d_5a);
    tick();

    // ---- simultaneous Icache 0x40 and Dcache 0x80 (last grant was DC) ----
    ic_valid_req_i = 1'b1; ic_addr_i = 32'h40;
    dc_valid_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h80; dc_wdata_i = '0;
    tick();
    ic_valid_req_i = 1'b0; dc_valid_req_i = 1'b0;
    check("sim_first_valid", DATA_W'(mem_valid_req_o), 1);
    check("sim_first_addr",  DATA_W'(mem_addr_o), FIRST_IS_DC ? 32'h80 : 32'h40);
    tick();
    mem_respond(d_77);
    check("sim_first_rdy", DATA_W'(FIRST_IS_DC ? dc_ready_o : ic_ready_o), 1);
    check("sim_other_rdy", DATA_W'(FIRST_IS_DC ? ic_ready_o : dc_ready_o), 0);
    check("sim_gap",       DATA_W'(mem_valid_req_o), 0);
    tick();
    check("sim_second_valid", DATA_W'(mem_valid_req_o), 1);
    check("sim_second_addr",  DATA_W'(mem_addr_o), FIRST_IS_DC ? 32'h40 : 32'h80);
    mem_respond(d_88);
    check("sim_second_rdy", DATA_W'(FIRST_IS_DC ? ic_ready_o : dc_ready_o), 1);
    check("sim_ic_data", ic_data_o, FIRST_IS_DC ? d_88 : d_77);
    check("sim_dc_data", dc_rdata_o, FIRST_IS_DC ? d_77 : d_88);
    tick();

    // ---- Icache redirect ----
    ic_pulse(32'h100);
    check("redir_addr0", DATA_W'(mem_addr_o), 32'h100);
    ic_pulse(32'h300);
    mem_respond(d_11);
    check("redir_dropped", DATA_W'(ic_ready_o), 0);
    check("redir_gap",     DATA_W'(mem_valid_req_o), 0);
    tick();
    check("redir_reissue", DATA_W'(mem_valid_req_o), 1);
    check("redir_addr1",   DATA_W'(mem_addr_o), 32'h300);
    check("redir_no_rdy",  DATA_W'(ic_ready_o), 0);
    tick();
    mem_respond(d_33);
    check("redir_ready", DATA_W'(ic_ready_o), 1);
    check("redir_data",  ic_data_o, d_33);
    tick();
    check("redir_ready_end", DATA_W'(ic_ready_o), 0);
    check("redir_no_more",   DATA_W'(mem_valid_req_o), 0);

    // ---- Dcache pulse while in flight is ignored ----
    dc_pulse(1'b0, 32'h5000, '0);
    check("viol_addr", DATA_W'(mem_addr_o), 32'h5000);
    dc_pulse(1'b0, 32'h6000, '0);
    mem_respond(d_c3);
    check("viol_ready", DATA_W'(dc_ready_o), 1);
    tick();
    check("viol_no_issue_a", DATA_W'(mem_valid_req_o), 0);
    tick();
    check("viol_no_issue_b", DATA_W'(mem_valid_req_o), 0);

    // ---- response and same-owner pulse in the same cycle ----
    ic_pulse(32'h700);
    check("same_addr0", DATA_W'(mem_addr_o), 32'h700);
    tick();
    ic_valid_req_i = 1'b1; ic_addr_i = 32'h800;
    mem_respond(d_77);
    ic_valid_req_i = 1'b0;
    check("same_ready", DATA_W'(ic_ready_o), 1);
    check("same_data",  ic_data_o, d_77);
    tick();
    check("same_issue", DATA_W'(mem_valid_req_o), 1);
    check("same_addr1", DATA_W'(mem_addr_o), 32'h800);
    mem_respond(d_88);
    check("same_ready2", DATA_W'(ic_ready_o), 1);
    check("same_data2",  ic_data_o, d_88);
    tick();

    // ---- reset in WAIT_DC, then a stale response ----
    dc_pulse(1'b0, 32'h4000, '0);
    check("rst_issue", DATA_W'(mem_valid_req_o), 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick();
    rst_n = 1'b1;
    tick();
    mem_respond(d_c3);
    check("rst_stale_rdy",   DATA_W'(dc_ready_o), 0);
    check("rst_stale_valid", DATA_W'(mem_valid_req_o), 0);
    check("rst_stale_data",  dc_rdata_o, '0);
    tick();
    check("rst_idle", DATA_W'(mem_valid_req_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single refill/memory port between the instruction cache and the data cache. It captures one-cycle request pulses from either cache and issues one memory transaction at a time. Each memory response is routed back as a one-cycle ready pulse with data to the requester that owns it. It sits between the caches and the memory model/bus, one instance per core.

## Interface
- ADDR_W, 32, address width of all address ports
- DATA_W, 128, line width of all data ports (one cache block)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- ic_valid_req_i  input  1  Icache request pulse (one cycle)
- ic_addr_i  input  ADDR_W  Icache block-aligned address, valid with pulse
- ic_ready_o  output  1  one-cycle response pulse to Icache
- ic_data_o  output  DATA_W  refill line, valid while ic_ready_o=1
- dc_valid_req_i  input  1  Dcache request pulse (one cycle)
- dc_we_i  input  1  Dcache write (1) / read (0), valid with pulse
- dc_addr_i  input  ADDR_W  Dcache block-aligned address
- dc_wdata_i  input  DATA_W  Dcache write-back line
- dc_ready_o  output  1  one-cycle response pulse to Dcache (read data or write ack)
- dc_rdata_o  output  DATA_W  read line, valid while dc_ready_o=1
- mem_valid_req_o  output  1  one-cycle request pulse to memory
- mem_we_o, mem_addr_o, mem_wdata_o  output  1/ADDR_W/DATA_W  request fields, held stable until mem_ready_i
- mem_ready_i  input  1  memory response pulse
- mem_rdata_i  input  DATA_W  memory read line, valid with mem_ready_i

## Operation
- Reset: all outputs 0, state IDLE, both pending slots empty, drop flag 0, last_grant=IC.
- Pending slots: one per requester, holding valid, address, and for Dcache also we and wdata. Effective pending = slot valid OR same-cycle incoming pulse, so a pulse is arbitrable in the cycle it arrives.
- States:
  - IDLE: if any effective pending, grant one, register mem_* fields, pulse mem_valid_req_o for one cycle, clear that slot, go to WAIT_IC or WAIT_DC. Otherwise stay.
  - WAIT_IC / WAIT_DC: mem_valid_req_o=0. On mem_ready_i, register the response to the owner's ready/data outputs (unless dropped) and go to IDLE.
- mem_ready_i in IDLE is ignored.
- Icache re-request (jump redirect):
  - ic pulse while IC slot pending but not issued: address overwritten, latest wins.
  - ic pulse in WAIT_IC: set drop flag and store the new address in the IC slot. The in-flight response produces no ic_ready_o. The drop flag clears on that response. The new request is then arbitrated normally.
- Dcache pulse while a Dcache request is pending or in flight: protocol violation. The pulse is ignored and the slot is unchanged.
- Arbitration when both are pending: Dcache wins (see Configuration).
- Simultaneous mem_ready_i and a new pulse from the same owner: the response completes (drop flag not set). The pulse is stored in the slot.
- ic_data_o and dc_rdata_o hold their last value between pulses. On a write ack, dc_rdata_o is unchanged.

## Timing
- Request pulse at cycle T with arbiter IDLE and no contention: mem_valid_req_o=1 in T+1.
- mem_ready_i at cycle R: owner ready pulse in R+1. FSM is IDLE in R+1, so the next mem_valid_req_o is at earliest R+2.
- Exactly one transaction outstanding at any time. mem_valid_req_o is never high in WAIT_*.
- Reset mid-transaction: immediate return to reset values. A late mem_ready_i arriving after reset is ignored (IDLE).

## Configuration
- MEM_ARB_RR_EN defined: round-robin. When both are pending, grant the requester other than last_grant. last_grant updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, Dcache always wins. last_grant logic is absent.

## Test plan
- Single Icache read: ic pulse addr 0x0000_0100 at T. Expect mem_valid_req_o=1, mem_addr_o=0x100, mem_we_o=0 at T+1. Memory returns 0xA5…A5 at R. Expect ic_ready_o=1 with ic_data_o=0xA5…A5 at R+1, dc_ready_o=0.
- Dcache write: dc pulse we=1, addr 0x2000, wdata 0x1234…. Expect mem_we_o=1 and fields matching. mem_ready_i → dc_ready_o pulse one cycle later, dc_rdata_o unchanged.
- Simultaneous ic (0x40) and dc (0x80) pulses in the same cycle:
  - Without the macro: Dcache issued first, Icache issued at R+2.
  - With MEM_ARB_RR_EN and last_grant=DC: Icache issued first.
- Icache redirect: ic 0x100 issued, ic 0x300 pulses during WAIT_IC. Expect no ic_ready_o for the 0x100 response, then mem_addr_o=0x300 issued, then exactly one ic_ready_o carrying the 0x300 data.
- Reset asserted in WAIT_DC, deasserted, then stale mem_ready_i: all outputs 0, no dc_ready_o, no mem_valid_req_o.
